// File: rtl/fetch_decode_register.sv
// fetch_decode_register: fetch/decode pipeline register with 2-entry skid buffer, flush and NOP fill; optional FETCH_DECODE_BUBBLE_COUNT_EN bubble counter
module fetch_decode_register #(
    parameter int DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] NOP_INSTR = 32'h00000013
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] InstrF_i,
    input  logic [DATA_WIDTH-1:0] PCF_i,
    input  logic [DATA_WIDTH-1:0] PCPlus4F_i,
    input  logic                  ValidF_i,
    output logic                  ReadyF_o,
    input  logic                  StallD_i,
    input  logic                  FlushD_i,
    output logic [DATA_WIDTH-1:0] InstrD_o,
    output logic [DATA_WIDTH-1:0] PCD_o,
    output logic [DATA_WIDTH-1:0] PCPlus4D_o,
    output logic                  ValidD_o
`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
    ,
    output logic [31:0]           BubbleCountD_o
`endif
);
    logic                  mainValid, skidValid;
    logic [DATA_WIDTH-1:0] mainInstr, mainPc, mainPc4;
    logic [DATA_WIDTH-1:0] skidInstr, skidPc, skidPc4;
    logic                  accept, consume;

    // Ready depends on state only, so decode stalls never reach fetch combinationally
    assign ReadyF_o   = ~skidValid;
    assign ValidD_o   = mainValid;
    assign InstrD_o   = mainValid ? mainInstr : NOP_INSTR;
    assign PCD_o      = mainPc;
    assign PCPlus4D_o = mainPc4;
    assign accept     = ValidF_i & ReadyF_o;
    assign consume    = mainValid & ~StallD_i;

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
            mainInstr <= NOP_INSTR;
            mainPc    <= '0;
            mainPc4   <= '0;
            skidInstr <= NOP_INSTR;
            skidPc    <= '0;
            skidPc4   <= '0;
        end else if (FlushD_i) begin
            mainValid <= 1'b0;
            skidValid <= 1'b0;
        end else if (!mainValid) begin
            if (accept) begin
                mainValid <= 1'b1;
                mainInstr <= InstrF_i;
                mainPc    <= PCF_i;
                mainPc4   <= PCPlus4F_i;
            end
        end else if (!skidValid) begin
            if (consume && accept) begin
                mainInstr <= InstrF_i;
                mainPc    <= PCF_i;
                mainPc4   <= PCPlus4F_i;
            end else if (consume) begin
                mainValid <= 1'b0;
            end else if (accept) begin
                skidValid <= 1'b1;
                skidInstr <= InstrF_i;
                skidPc    <= PCF_i;
                skidPc4   <= PCPlus4F_i;
            end
        end else if (consume) begin
            mainInstr <= skidInstr;
            mainPc    <= skidPc;
            mainPc4   <= skidPc4;
            skidValid <= 1'b0;
        end
    end

`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
    // Counts every edge where decode receives nothing new; flush leaves it alone
    always_ff @(negedge clk or posedge rst) begin
        if (rst)
            BubbleCountD_o <= '0;
        else if (!consume && BubbleCountD_o != 32'hFFFFFFFF)
            BubbleCountD_o <= BubbleCountD_o + 32'd1;
    end
`endif
endmodule

// File: tb/tb_fetch_decode_register.sv
// tb_fetch_decode_register: directed + random scoreboard bench for fetch_decode_register
module tb_fetch_decode_register;
    localparam logic [31:0] NOP = 32'h00000013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] InstrF_i = '0, PCF_i = '0, PCPlus4F_i = '0;
    logic        ValidF_i = 1'b0, StallD_i = 1'b0, FlushD_i = 1'b0;
    logic        ReadyF_o, ValidD_o;
    logic [31:0] InstrD_o, PCD_o, PCPlus4D_o;
`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
    logic [31:0] BubbleCountD_o;
`endif

    entry_t      q[$];
    logic [31:0] bubbles = '0;
    int          total = 0;
    int          passed = 0;

    always #5 clk = ~clk;

    fetch_decode_register dut (
        .clk(clk), .rst(rst),
        .InstrF_i(InstrF_i), .PCF_i(PCF_i), .PCPlus4F_i(PCPlus4F_i),
        .ValidF_i(ValidF_i), .ReadyF_o(ReadyF_o),
        .StallD_i(StallD_i), .FlushD_i(FlushD_i),
        .InstrD_o(InstrD_o), .PCD_o(PCD_o), .PCPlus4D_o(PCPlus4D_o),
        .ValidD_o(ValidD_o)
`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
        , .BubbleCountD_o(BubbleCountD_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic checkOutputs();
        chk("valid", {31'd0, ValidD_o}, {31'd0, q.size() != 0});
        chk("ready", {31'd0, ReadyF_o}, {31'd0, q.size() < 2});
        if (q.size() != 0) begin
            chk("instr", InstrD_o, q[0].instr);
            chk("pc", PCD_o, q[0].pc);
            chk("pc4", PCPlus4D_o, q[0].pc + 32'd4);
        end else begin
            chk("nop", InstrD_o, NOP);
        end
`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
        chk("bubbles", BubbleCountD_o, bubbles);
`endif
    endtask

    // Entered just after a rising edge: check, drive, update the model, pass the falling edge.
    task automatic cyc(input logic vf, input logic [31:0] pc, input logic [31:0] instr,
                       input logic stall, input logic flush);
        logic acc, con;
        checkOutputs();
        ValidF_i   = vf;
        PCF_i      = pc;
        PCPlus4F_i = pc + 32'd4;
        InstrF_i   = instr;
        StallD_i   = stall;
        FlushD_i   = flush;
        acc = vf && q.size() < 2;
        con = q.size() != 0 && !stall;
        if (!con && bubbles != 32'hFFFFFFFF) bubbles++;
        if (flush) q.delete();
        else begin
            if (con) void'(q.pop_front());
            if (acc) q.push_back('{instr: instr, pc: pc});
        end
        @(posedge clk);
    endtask

    task automatic asyncReset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, ValidD_o}, 32'd0);
        chk("rst_ready", {31'd0, ReadyF_o}, 32'd1);
        chk("rst_instr", InstrD_o, NOP);
        chk("rst_pc", PCD_o, 32'd0);
        q.delete();
        bubbles = '0;
        ValidF_i = 1'b0;
        StallD_i = 1'b0;
        FlushD_i = 1'b0;
        @(posedge clk);
        rst = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        @(posedge clk);
        chk("init_pc4", PCPlus4D_o, 32'd0);
        rst = 1'b0;
        // streaming
        for (int i = 0; i < 4; i++) cyc(1, 32'(4 * i), 32'h00500093 + 32'(i), 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // skid fill and release
        cyc(1, 32'h10, 32'h10, 0, 0);
        cyc(1, 32'h14, 32'h14, 1, 0);
        cyc(1, 32'h18, 32'h18, 1, 0);
        cyc(1, 32'h18, 32'h18, 0, 0);
        cyc(1, 32'h18, 32'h18, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // flush with simultaneous accept
        cyc(1, 32'h20, 32'h20, 0, 0);
        cyc(1, 32'h24, 32'h24, 1, 0);
        cyc(1, 32'h28, 32'h28, 0, 1);
        cyc(1, 32'h40, 32'h40, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // stall on empty
        cyc(0, 0, 0, 1, 0);
        cyc(1, 32'h30, 32'h30, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 60; i++)
            cyc(1'($urandom_range(0, 1)), 32'h100 + 32'(4 * i), 32'hA000 + 32'(i),
                $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
        // asynchronous reset with both entries full
        cyc(1, 32'h50, 32'h50, 1, 0);
        cyc(1, 32'h54, 32'h54, 1, 0);
        chk("two_full_ready", {31'd0, ReadyF_o}, 32'd0);
        asyncReset();
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        cyc(1, 32'h60, 32'h60, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 0, 1);
`ifdef FETCH_DECODE_BUBBLE_COUNT_EN
        chk("bubble_five", BubbleCountD_o, 32'd5);
`endif
        cyc(0, 0, 0, 0, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
